// File: rtl/match_resp_reorder.sv
// ---------------------------------------------------------------------------
// match_resp_reorder
//
// Tags outgoing match requests with a reorder-buffer slot index, collects
// match responses that may come back out of order, and releases
// (user, match_len) results to the job PE strictly in request order.
//
// Ports
//   clk, rst                         clock, async active-high reset
//   in_req_*                         request from job PE (valid/ready + payload)
//   match_req_*                      request to match PE (tag = ROB slot)
//   match_resp_*                     response from match PE (always ready)
//   out_valid/out_ready/out_*        in-order result to job PE
//   err                              sticky protocol-error flag
//
// Build option
//   MATCH_RESP_REORDER_ERR_CHECK_EN  when defined, responses to a non-busy or
//                                    already-done slot, or with non-zero upper
//                                    tag bits, are dropped and set err.
//                                    When undefined, every response writes its
//                                    slot and err is tied low.
// ---------------------------------------------------------------------------
module match_resp_reorder #(
    parameter int TAG_BITS           = 8,
    parameter int ROB_DEPTH_LOG2     = 2,
    parameter int USER_BITS          = 16,
    parameter int ADDR_WIDTH         = 32,
    parameter int MAX_MATCH_LEN_LOG2 = 8
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          in_req_valid,
    output logic                          in_req_ready,
    input  logic [ADDR_WIDTH-1:0]         in_req_head_addr,
    input  logic [ADDR_WIDTH-1:0]         in_req_history_addr,
    input  logic [USER_BITS-1:0]          in_req_user,

    output logic                          match_req_valid,
    input  logic                          match_req_ready,
    output logic [TAG_BITS-1:0]           match_req_tag,
    output logic [ADDR_WIDTH-1:0]         match_req_head_addr,
    output logic [ADDR_WIDTH-1:0]         match_req_history_addr,

    input  logic                          match_resp_valid,
    output logic                          match_resp_ready,
    input  logic [TAG_BITS-1:0]           match_resp_tag,
    input  logic [MAX_MATCH_LEN_LOG2:0]   match_resp_match_len,

    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [USER_BITS-1:0]          out_user,
    output logic [MAX_MATCH_LEN_LOG2:0]   out_match_len,

    output logic                          err
);

    localparam int DEPTH = 1 << ROB_DEPTH_LOG2;
    localparam int LEN_W = MAX_MATCH_LEN_LOG2 + 1;
    localparam logic [ROB_DEPTH_LOG2:0] DEPTH_CNT = (ROB_DEPTH_LOG2 + 1)'(DEPTH);

    logic [ROB_DEPTH_LOG2-1:0] alloc_ptr;
    logic [ROB_DEPTH_LOG2-1:0] retire_ptr;
    logic [ROB_DEPTH_LOG2:0]   count;

    logic [DEPTH-1:0]                busy;
    logic [DEPTH-1:0]                done;
    logic [DEPTH-1:0][USER_BITS-1:0] user_arr;
    logic [DEPTH-1:0][LEN_W-1:0]     len_arr;

    logic                      full;
    logic                      issue_fire;
    logic                      retire_fire;
    logic [ROB_DEPTH_LOG2-1:0] resp_idx;
    logic                      upper_zero;
    logic                      resp_legal;
    logic                      resp_wr;

    // Full is purely a function of registered count: a retire in the same
    // cycle does not free a slot for issue until the next cycle.
    assign full       = (count == DEPTH_CNT);
    assign issue_fire = in_req_valid & in_req_ready;

    assign match_req_valid        = in_req_valid & ~full;
    assign in_req_ready           = match_req_ready & ~full;
    assign match_req_tag          = TAG_BITS'(alloc_ptr);
    assign match_req_head_addr    = in_req_head_addr;
    assign match_req_history_addr = in_req_history_addr;

    assign match_resp_ready = 1'b1;
    assign resp_idx         = match_resp_tag[ROB_DEPTH_LOG2-1:0];
    // Shift form works even when TAG_BITS == ROB_DEPTH_LOG2 (no upper bits).
    assign upper_zero       = ((match_resp_tag >> ROB_DEPTH_LOG2) == '0);
    assign resp_legal       = busy[resp_idx] & ~done[resp_idx] & upper_zero;

`ifdef MATCH_RESP_REORDER_ERR_CHECK_EN
    assign resp_wr = match_resp_valid & resp_legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (match_resp_valid && !resp_legal)
            err <= 1'b1;
    end
`else
    logic unused_legal;
    assign resp_wr      = match_resp_valid;
    assign err          = 1'b0;
    assign unused_legal = resp_legal;
`endif

    assign out_valid     = busy[retire_ptr] & done[retire_ptr];
    assign out_user      = user_arr[retire_ptr];
    assign out_match_len = len_arr[retire_ptr];
    assign retire_fire   = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr  <= '0;
            retire_ptr <= '0;
            count      <= '0;
        end else begin
            if (issue_fire)  alloc_ptr  <= alloc_ptr + 1'b1;
            if (retire_fire) retire_ptr <= retire_ptr + 1'b1;
            if (issue_fire && !retire_fire)
                count <= count + 1'b1;
            else if (retire_fire && !issue_fire)
                count <= count - 1'b1;
        end
    end

    // Per-slot state. Retire, issue and response cannot legally target the
    // same slot in one cycle; the later statements win only in the
    // unchecked build where a stray response may hit any slot.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        localparam logic [ROB_DEPTH_LOG2-1:0] IDX = ROB_DEPTH_LOG2'(e);

        logic                 busy_q;
        logic                 done_q;
        logic [USER_BITS-1:0] user_q;
        logic [LEN_W-1:0]     len_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                busy_q <= 1'b0;
                done_q <= 1'b0;
                user_q <= '0;
                len_q  <= '0;
            end else begin
                if (retire_fire && retire_ptr == IDX) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                if (issue_fire && alloc_ptr == IDX) begin
                    busy_q <= 1'b1;
                    done_q <= 1'b0;
                    user_q <= in_req_user;
                end
                if (resp_wr && resp_idx == IDX) begin
                    done_q <= 1'b1;
                    len_q  <= match_resp_match_len;
                end
            end
        end

        assign busy[e]     = busy_q;
        assign done[e]     = done_q;
        assign user_arr[e] = user_q;
        assign len_arr[e]  = len_q;
    end

endmodule

// File: tb/tb_match_resp_reorder.sv
module tb_match_resp_reorder;

    localparam int TAG_BITS = 8;
    localparam int RDL2     = 2;
    localparam int UB       = 16;
    localparam int AW       = 32;
    localparam int MLL2     = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_req_valid, in_req_ready;
    logic [AW-1:0]   in_req_head_addr, in_req_history_addr;
    logic [UB-1:0]   in_req_user;
    logic            match_req_valid, match_req_ready;
    logic [TAG_BITS-1:0] match_req_tag;
    logic [AW-1:0]   match_req_head_addr, match_req_history_addr;
    logic            match_resp_valid, match_resp_ready;
    logic [TAG_BITS-1:0] match_resp_tag;
    logic [MLL2:0]   match_resp_match_len;
    logic            out_valid, out_ready;
    logic [UB-1:0]   out_user;
    logic [MLL2:0]   out_match_len;
    logic            err;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MATCH_RESP_REORDER_ERR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    match_resp_reorder #(
        .TAG_BITS(TAG_BITS), .ROB_DEPTH_LOG2(RDL2), .USER_BITS(UB),
        .ADDR_WIDTH(AW), .MAX_MATCH_LEN_LOG2(MLL2)
    ) dut (
        .clk(clk), .rst(rst),
        .in_req_valid(in_req_valid), .in_req_ready(in_req_ready),
        .in_req_head_addr(in_req_head_addr), .in_req_history_addr(in_req_history_addr),
        .in_req_user(in_req_user),
        .match_req_valid(match_req_valid), .match_req_ready(match_req_ready),
        .match_req_tag(match_req_tag), .match_req_head_addr(match_req_head_addr),
        .match_req_history_addr(match_req_history_addr),
        .match_resp_valid(match_resp_valid), .match_resp_ready(match_resp_ready),
        .match_resp_tag(match_resp_tag), .match_resp_match_len(match_resp_match_len),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_user(out_user), .out_match_len(out_match_len),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_count", 32'(dut.count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        #2 rst = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] ha, input logic [AW-1:0] hi,
                         input logic [UB-1:0] user, input int exp_tag);
        @(negedge clk);
        in_req_valid = 1'b1;
        in_req_head_addr = ha;
        in_req_history_addr = hi;
        in_req_user = user;
        #1;
        chk("iss_mvalid", 32'(match_req_valid), 1);
        chk("iss_ready", 32'(in_req_ready), 1);
        chk("iss_tag", 32'(match_req_tag), 32'(exp_tag));
        chk("iss_head", match_req_head_addr, ha);
        chk("iss_hist", match_req_history_addr, hi);
        @(posedge clk);
        #1 in_req_valid = 1'b0;
    endtask

    task automatic respond(input logic [TAG_BITS-1:0] tag, input logic [MLL2:0] len);
        @(negedge clk);
        match_resp_valid = 1'b1;
        match_resp_tag = tag;
        match_resp_match_len = len;
        @(posedge clk);
        #1 match_resp_valid = 1'b0;
    endtask

    task automatic retire(input logic [UB-1:0] user, input logic [MLL2:0] len);
        @(negedge clk);
        chk("ret_valid", 32'(out_valid), 1);
        chk("ret_user", 32'(out_user), 32'(user));
        chk("ret_len", 32'(out_match_len), 32'(len));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_req_valid = 1'b0; in_req_head_addr = '0; in_req_history_addr = '0; in_req_user = '0;
        match_req_ready = 1'b1;
        match_resp_valid = 1'b0; match_resp_tag = '0; match_resp_match_len = '0;
        out_ready = 1'b0;
        #3;
        chk("reset_mvalid", 32'(match_req_valid), 0);
        chk("reset_in_ready", 32'(in_req_ready), 1);
        chk("reset_resp_ready", 32'(match_resp_ready), 1);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_err", 32'(err), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single request, response lands at the head one cycle later.
        issue(100, 40, 7, 0);
        chk("single_pre_valid", 32'(out_valid), 0);
        respond(0, 12);
        chk("single_lat_valid", 32'(out_valid), 1);
        retire(7, 12);
        #1 chk("single_empty", 32'(out_valid), 0);

        // Out-of-order responses 2,0,3,1.
        pulse_rst();
        for (int i = 0; i < 4; i++)
            issue(32'(200 + i), 32'(300 + i), UB'(i + 1), i);
        @(negedge clk);
        in_req_valid = 1'b1;
        #1;
        chk("full_in_ready", 32'(in_req_ready), 0);
        chk("full_mvalid", 32'(match_req_valid), 0);
        chk("full_count", 32'(dut.count), 4);
        in_req_valid = 1'b0;
        respond(2, 5);
        chk("ooo_wait_head", 32'(out_valid), 0);
        respond(0, 6);
        chk("ooo_head_valid", 32'(out_valid), 1);
        respond(3, 7);
        respond(1, 8);

        // Full with a retire in the same cycle: no issue that cycle.
        @(negedge clk);
        in_req_valid = 1'b1; in_req_user = 9; out_ready = 1'b1;
        #1;
        chk("full_ret_in_ready", 32'(in_req_ready), 0);
        chk("full_ret_user", 32'(out_user), 1);
        chk("full_ret_len", 32'(out_match_len), 6);
        @(posedge clk);
        #1;
        in_req_valid = 1'b0; out_ready = 1'b0;
        chk("full_ret_count", 32'(dut.count), 3);
        issue(1, 2, 9, 0);

        // Backpressure on the head.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_user", 32'(out_user), 2);
            chk("bp_len", 32'(out_match_len), 8);
            chk("bp_count", 32'(dut.count), 4);
        end
        retire(2, 8);
        retire(3, 5);
        retire(4, 7);
        respond(0, 33);
        retire(9, 33);
        #1 chk("ooo_drained", 32'(dut.count), 0);

        // Response to head coincident with out_ready: retires next cycle.
        issue(5, 6, 20, 1);
        @(negedge clk);
        match_resp_valid = 1'b1; match_resp_tag = 1; match_resp_match_len = 3;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        match_resp_valid = 1'b0; out_ready = 1'b0;
        chk("coinc_count", 32'(dut.count), 1);
        retire(20, 3);

        // Issue into one slot and respond to another in the same cycle.
        issue(7, 8, 21, 2);
        @(negedge clk);
        in_req_valid = 1'b1; in_req_user = 22;
        match_resp_valid = 1'b1; match_resp_tag = 2; match_resp_match_len = 4;
        #1 chk("both_tag", 32'(match_req_tag), 3);
        @(posedge clk);
        #1;
        in_req_valid = 1'b0; match_resp_valid = 1'b0;
        chk("both_count", 32'(dut.count), 2);
        retire(21, 4);
        respond(3, 5);
        retire(22, 5);
        issue(9, 9, 23, 0);  // pointer wrapped 3 -> 0

        // Illegal responses.
        pulse_rst();
        respond(3, 9);
        chk("err_nonbusy", 32'(err), 32'(CHK));
        chk("err_out_valid", 32'(out_valid), 0);
        chk("err_count", 32'(dut.count), 0);
        issue(1, 1, 30, 0);
        respond(8'h10, 11);
        chk("err_upper_valid", 32'(out_valid), CHK ? 0 : 1);
        pulse_rst();
        chk("err_cleared", 32'(err), 0);

        // Reset mid-flight; late response is dropped.
        issue(1, 1, 40, 0);
        issue(2, 2, 41, 1);
        issue(3, 3, 42, 2);
        respond(0, 1);
        chk("mid_pre_count", 32'(dut.count), 3);
        pulse_rst();
        respond(1, 5);
        chk("mid_late_valid", 32'(out_valid), 0);
        chk("mid_late_err", 32'(err), 32'(CHK));
        issue(4, 4, 43, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/match_resp_reorder.md
# match_resp_reorder

Sits between a job PE and one match PE. It assigns scoreboard tags to outgoing match requests and holds per-request context in a small reorder buffer (ROB). Match responses can come back out of order, so the block releases `(user, match_len)` results to the job PE strictly in request order. This lets the job PE consume match lengths positionally, without tag bookkeeping.

## Interface
Parameters:
- `TAG_BITS`, default 8: width of the match PE tag bus. Must be ≥ `ROB_DEPTH_LOG2`.
- `ROB_DEPTH_LOG2`, default 2: ROB depth = 2^`ROB_DEPTH_LOG2` entries.
- `USER_BITS`, default 16: opaque job PE context stored per entry and returned with the result.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_req_valid` in 1 / `in_req_ready` out 1: request handshake from the job PE.
- `in_req_head_addr` in `ADDR_WIDTH`, `in_req_history_addr` in `ADDR_WIDTH`, `in_req_user` in `USER_BITS`: request payload.
- `match_req_valid` out 1 / `match_req_ready` in 1: request handshake to the match PE.
- `match_req_tag` out `TAG_BITS`, `match_req_head_addr` out `ADDR_WIDTH`, `match_req_history_addr` out `ADDR_WIDTH`: request payload to the match PE.
- `match_resp_valid` in 1 / `match_resp_ready` out 1: response handshake from the match PE.
- `match_resp_tag` in `TAG_BITS`, `match_resp_match_len` in `MAX_MATCH_LEN_LOG2+1`: response payload.
- `out_valid` out 1 / `out_ready` in 1: in-order result handshake to the job PE.
- `out_user` out `USER_BITS`, `out_match_len` out `MAX_MATCH_LEN_LOG2+1`: result payload.
- `err` out 1: sticky protocol-error flag.

## Operation
State:
- `alloc_ptr` and `retire_ptr`, each `ROB_DEPTH_LOG2` bits, wrapping modulo depth.
- `count`, `ROB_DEPTH_LOG2+1` bits.
- Per entry: `busy`, `done`, `user`, `len`.

Issue path (combinational handshake, no added latency):
- `match_req_valid = in_req_valid & ~full`
- `in_req_ready = match_req_ready & ~full`
- `full = (count == 2^ROB_DEPTH_LOG2)`. `full` is a registered-state function only; there is no same-cycle retire credit.
- `match_req_tag = alloc_ptr`, zero-extended to `TAG_BITS`. Addresses pass through unchanged.
- On fire (`in_req_valid & in_req_ready`):
  - `entry[alloc_ptr]`: `busy←1`, `done←0`, `user←in_req_user`.
  - `alloc_ptr++`.

Response path:
- `match_resp_ready` is constant 1 after reset; a slot always exists for a legal tag.
- On `match_resp_valid`, index = `match_resp_tag[ROB_DEPTH_LOG2-1:0]`:
  - Legal (entry `busy & ~done`, upper tag bits zero): `done←1`, `len←match_resp_match_len`.
  - Illegal: response dropped, ROB unchanged, `err` handled per Configuration.

Retire path:
- `out_valid = busy[retire_ptr] & done[retire_ptr]`.
- `out_user` and `out_match_len` come from `entry[retire_ptr]`. Values are held stable while `out_valid & ~out_ready`.
- On `out_valid & out_ready`: `busy←0`, `done←0`, `retire_ptr++`.

Counter update:
- `count` += issue fire, −= retire fire. Both in one cycle leaves `count` unchanged.

## Timing
Reset values (asynchronous assert, all registers cleared):
- All pointers 0, `count` 0, all `busy`/`done` 0.
- `match_req_valid` 0, `in_req_ready` = `match_req_ready`, `match_resp_ready` 1, `out_valid` 0, `err` 0.

Latency:
- Request: 0 cycles, in-to-match combinational.
- Response at edge N → `out_valid` at cycle N+1 if that entry is at the head. Otherwise it waits until all older entries retire.

Boundary conditions:
- Full: no issue that cycle, even if a retire fires that cycle.
- Empty: `out_valid` = 0.
- Simultaneous response to the head entry and `out_ready`: the response is captured. The retire decision uses the pre-edge `done`, so the entry retires the next cycle.
- Simultaneous issue into a slot and response to a different slot: both take effect.
- Pointer wrap: `2^ROB_DEPTH_LOG2−1 → 0`.
- Reset mid-operation: all in-flight entries are discarded. Late match PE responses after reset are illegal (entries not busy) and are dropped.

## Configuration
- `MATCH_RESP_REORDER_ERR_CHECK_EN` defined:
  - `err` is set on any illegal response (non-busy entry, already-done entry, or non-zero upper tag bits).
  - `err` holds until `rst`.
- Undefined:
  - `err` tied to 0.
  - Legality check removed: every response writes `done←1` and `len` into the indexed entry unconditionally.

## Test plan
- Single request: head=100, hist=40, user=7. Response tag 0, len=12 → one cycle later `out_valid`, `out_user`=7, `out_match_len`=12.
- Out of order: 4 requests, users 1–4. Responses arrive in tag order 2,0,3,1 with lens 5,6,7,8 → outputs (1,6),(2,8),(3,5),(4,7) in that order. `out_valid` is low until tag 0 arrives.
- Full: 4 issues with no responses → `in_req_ready`=0 and `match_req_valid`=0. Respond and retire tag 0 → issue resumes with tag 0 (wrap).
- Backpressure: `out_ready`=0 for 5 cycles with the head done → `out_user`/`out_match_len` stable. No retire occurs and `count` is unchanged.
- Error (macro defined): response tag 3 with entry 3 not busy → `err`=1 next cycle and ROB unchanged. Assert `rst` → `err`=0.
- Reset mid-flight: 3 entries busy, pulse `rst` → `count`=0, `out_valid`=0, next issued tag = 0.
